light_frame_scheduler: RTL and testbench

LIGHT_FRAME_SCHEDULER -- requirements
Module: light_frame_scheduler

---
 rtl/light_sched_pkg.sv | 17 +
 rtl/light_frame_scheduler_if.sv | 33 +++
 rtl/light_bank_ram.sv | 40 ++++
 rtl/light_frame_scheduler.sv | 135 +++++++++++++
 tb/tb_light_frame_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/light_sched_pkg.sv
// Shared constants and the scheduler state type for the backlight frame scheduler.
package light_sched_pkg;

  localparam int unsigned ZONES     = 360;
  localparam int unsigned ZONE_COLS = 24;
  localparam int unsigned IDX_W     = 9;
  localparam int unsigned LIGHT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STAT,
    START,
    FILTER,
    SWAP
  } state_t;

endpackage

// File: rtl/light_frame_scheduler_if.sv
// Frame control, filter result stream and LED-driver read port of the scheduler.
interface light_frame_scheduler_if;
  import light_sched_pkg::*;

  logic               frame_start;
  logic               stat_done;
  logic               filter_start;
  logic [LIGHT_W-1:0] light;
  logic [IDX_W-1:0]   light_index;
  logic               light_refresh;
  logic               filter_end;
  logic               rd_req;
  logic [IDX_W-1:0]   rd_index;
  logic [LIGHT_W-1:0] rd_data;
  logic               rd_valid;
  logic               bank_sel;
  logic               frame_ready;
  logic               frame_drop;
  logic               sched_err;

  modport master (
    output frame_start, stat_done, light, light_index, light_refresh, filter_end,
           rd_req, rd_index,
    input  filter_start, rd_data, rd_valid, bank_sel, frame_ready, frame_drop, sched_err
  );

  modport slave (
    input  frame_start, stat_done, light, light_index, light_refresh, filter_end,
           rd_req, rd_index,
    output filter_start, rd_data, rd_valid, bank_sel, frame_ready, frame_drop, sched_err
  );

endinterface

// File: rtl/light_bank_ram.sv
// Two banks of zone brightness words: one write port, one registered read port.
module light_bank_ram
  import light_sched_pkg::*;
#(
  parameter int unsigned ZONES = light_sched_pkg::ZONES
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic               wbank_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [LIGHT_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic               rbank_i,
  input  logic [IDX_W-1:0]   raddr_i,
  input  logic               rzero_i,
  output logic [LIGHT_W-1:0] rdata_o
);

  logic [LIGHT_W-1:0] mem_q [2][ZONES];
  logic [LIGHT_W-1:0] rdata_q;

  // Storage is deliberately not reset; the scheduler masks it until the first swap.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[rbank_i][raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/light_frame_scheduler.sv
// Per-frame sequencing of statistics, filter pass and double-buffered bank swap.
module light_frame_scheduler
  import light_sched_pkg::*;
#(
  parameter int unsigned ZONES          = light_sched_pkg::ZONES,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  light_frame_scheduler_if.slave  sched_if
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] ZLIM  = CNT_W'(ZONES);
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] zone_cnt_q;
  logic [CNT_W-1:0] zone_cnt_d;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_d;
  logic             refresh_q;
  logic             bank_sel_q;
  logic             buf_valid_q;
  logic             filter_start_q;
  logic             frame_ready_q;
  logic             frame_drop_q;
  logic             sched_err_q;
  logic             rd_valid_q;

  logic idx_ok;
  logic wr_en;
  logic rd_zero;

  assign idx_ok  = {1'b0, sched_if.light_index} < ZLIM;
  assign wr_en   = (state_q == FILTER) && sched_if.light_refresh && idx_ok;
  assign rd_zero = !buf_valid_q || !({1'b0, sched_if.rd_index} < ZLIM);

  // Zones are counted on refresh rising edges only; the count saturates rather than wrap.
  always_comb begin
    zone_cnt_d = zone_cnt_q;
    if (sched_if.light_refresh && !refresh_q && idx_ok && (zone_cnt_q != '1)) begin
      zone_cnt_d = zone_cnt_q + CNT_W'(1);
    end
    timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q        <= IDLE;
      zone_cnt_q     <= '0;
      timer_q        <= '0;
      refresh_q      <= 1'b0;
      bank_sel_q     <= 1'b0;
      buf_valid_q    <= 1'b0;
      filter_start_q <= 1'b0;
      frame_ready_q  <= 1'b0;
      frame_drop_q   <= 1'b0;
      sched_err_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
    end else begin
      filter_start_q <= 1'b0;
      frame_ready_q  <= 1'b0;
      frame_drop_q   <= sched_if.frame_start && (state_q != IDLE);
      rd_valid_q     <= sched_if.rd_req;
      refresh_q      <= sched_if.light_refresh;
      case (state_q)
        IDLE: begin
          if (sched_if.frame_start) begin
            state_q <= WAIT_STAT;
          end
        end
        WAIT_STAT: begin
          if (sched_if.stat_done) begin
            state_q        <= START;
            filter_start_q <= 1'b1;
          end
        end
        START: begin
          zone_cnt_q <= '0;
          timer_q    <= '0;
          state_q    <= FILTER;
        end
        FILTER: begin
          zone_cnt_q <= zone_cnt_d;
          timer_q    <= timer_d;
          // filter_end wins over a timeout landing in the same cycle.
          if (sched_if.filter_end) begin
            if (zone_cnt_q == ZLIM) begin
              state_q <= SWAP;
            end else begin
              sched_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end else if (timer_q == TLAST) begin
            sched_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        SWAP: begin
          bank_sel_q    <= ~bank_sel_q;
          frame_ready_q <= 1'b1;
          buf_valid_q   <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  light_bank_ram #(
    .ZONES (ZONES)
  ) u_bank_ram (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst),
    .we_i    (wr_en),
    .wbank_i (~bank_sel_q),
    .waddr_i (sched_if.light_index),
    .wdata_i (sched_if.light),
    .re_i    (sched_if.rd_req),
    .rbank_i (bank_sel_q),
    .raddr_i (sched_if.rd_index),
    .rzero_i (rd_zero),
    .rdata_o (sched_if.rd_data)
  );

  assign sched_if.filter_start = filter_start_q;
  assign sched_if.rd_valid     = rd_valid_q;
  assign sched_if.bank_sel     = bank_sel_q;
  assign sched_if.frame_ready  = frame_ready_q;
  assign sched_if.frame_drop   = frame_drop_q;
  assign sched_if.sched_err    = sched_err_q;

endmodule

// File: tb/tb_light_frame_scheduler.sv
// Randomized frame-level bench for light_frame_scheduler with a bank-array reference model.
module tb_light_frame_scheduler;

  localparam int ZONES   = 360;
  localparam int TIMEOUT = 8192;

  logic sys_clk;
  logic sys_rst;

  light_frame_scheduler_if sif ();

  light_frame_scheduler #(
    .ZONES          (ZONES),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sched_if (sif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errs   = 0;
  int fs_cnt   = 0;
  int fr_cnt   = 0;

  // Reference model: physical bank contents, presented bank and validity.
  logic [15:0] ref_mem [2][512];
  bit          ref_sel;
  bit          ref_valid;

  always @(posedge sys_clk) begin
    if (sif.filter_start === 1'b1) fs_cnt++;
    if (sif.frame_ready === 1'b1) fr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] model_read(input int idx);
    if (!ref_valid || idx >= ZONES) return 16'h0;
    return ref_mem[ref_sel][idx];
  endfunction

  task automatic read_check(input string tag, input int idx);
    logic [15:0] exp;
    exp = model_read(idx);
    sif.rd_req   = 1'b1;
    sif.rd_index = 9'(idx);
    tick();
    sif.rd_req = 1'b0;
    check_eq({tag, "_vld"}, sif.rd_valid, 1);
    check_eq(tag, sif.rd_data, exp);
  endtask

  task automatic enter_filter();
    sif.stat_done = 1'b1;
    tick();
    sif.stat_done   = 1'b0;
    sif.frame_start = 1'b1;
    tick();
    sif.frame_start = 1'b0;
    check_eq("idle_no_drop", sif.frame_drop, 0);
    tick();
    sif.stat_done = 1'b1;
    tick();
    sif.stat_done = 1'b0;
    check_eq("start_pulse", sif.filter_start, 1);
    tick();
    check_eq("start_single", sif.filter_start, 0);
  endtask

  task automatic run_filter(input int n_zones, input bit nominal, input bit drop_mid,
                            input bit drop_end);
    int          perm[ZONES];
    int          j, t, ridx, fr0;
    bit          wb;
    logic [15:0] v, exp;
    for (int i = 0; i < ZONES; i++) perm[i] = i;
    if (!nominal) begin
      for (int i = ZONES - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
    end
    wb = ~ref_sel;
    for (int k = 0; k < n_zones; k++) begin
      if (!nominal && $urandom_range(7, 0) == 0) begin
        sif.light         = 16'($urandom);
        sif.light_index   = 9'(ZONES + $urandom_range(511 - ZONES, 0));
        sif.light_refresh = 1'b1;
        tick();
        sif.light_refresh = 1'b0;
        tick();
      end
      v = nominal ? 16'(perm[k] * 2) : 16'($urandom);
      sif.light         = v;
      sif.light_index   = 9'(perm[k]);
      sif.light_refresh = 1'b1;
      if (drop_mid && k == n_zones / 2) sif.frame_start = 1'b1;
      tick();
      ref_mem[wb][perm[k]] = v;
      if (sif.frame_start) begin
        check_eq("frame_drop_mid", sif.frame_drop, 1);
        sif.frame_start = 1'b0;
      end
      sif.light_refresh = 1'b0;
      repeat ($urandom_range(2, 1)) tick();
    end
    fr0 = fr_cnt;
    sif.filter_end = 1'b1;
    if (drop_end) sif.frame_start = 1'b1;
    tick();
    sif.filter_end = 1'b0;
    if (drop_end) begin
      check_eq("frame_drop_end", sif.frame_drop, 1);
      sif.frame_start = 1'b0;
    end
    if (n_zones == ZONES) begin
      ridx = $urandom_range(ZONES - 1, 0);
      exp  = model_read(ridx);
      sif.rd_req   = 1'b1;
      sif.rd_index = 9'(ridx);
      tick();
      sif.rd_req = 1'b0;
      ref_sel   = wb;
      ref_valid = 1'b1;
      check_eq("swap_frame_ready", sif.frame_ready, 1);
      check_eq("swap_bank_sel", sif.bank_sel, wb);
      check_eq("swap_read_old", sif.rd_data, exp);
    end else begin
      check_eq("short_err", sif.sched_err, 1);
      repeat (3) tick();
      check_eq("short_no_ready", fr_cnt - fr0, 0);
      check_eq("short_bank_sel", sif.bank_sel, ref_sel);
    end
  endtask

  task automatic do_frame(input int n, input bit nominal, input bit dmid, input bit dend);
    int fs0;
    fs0 = fs_cnt;
    enter_filter();
    run_filter(n, nominal, dmid, dend);
    tick();
    check_eq("fs_pulses", fs_cnt - fs0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_fs"}, sif.filter_start, 0);
    check_eq({tag, "_fr"}, sif.frame_ready, 0);
    check_eq({tag, "_fd"}, sif.frame_drop, 0);
    check_eq({tag, "_rv"}, sif.rd_valid, 0);
    check_eq({tag, "_rd"}, sif.rd_data, 0);
    check_eq({tag, "_bs"}, sif.bank_sel, 0);
    check_eq({tag, "_err"}, sif.sched_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr0;
    sys_rst           = 1'b0;
    sif.frame_start   = 1'b0;
    sif.stat_done     = 1'b0;
    sif.light         = '0;
    sif.light_index   = '0;
    sif.light_refresh = 1'b0;
    sif.filter_end    = 1'b0;
    sif.rd_req        = 1'b0;
    sif.rd_index      = '0;
    ref_sel           = 1'b0;
    ref_valid         = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    sys_rst = 1'b1;
    tick();

    read_check("rd_pre_swap", 5);

    do_frame(ZONES, 1'b1, 1'b0, 1'b0);
    check_eq("nom_bank_sel", sif.bank_sel, 1);
    read_check("rd_idx100", 100);
    check_eq("rd_idx100_lit", sif.rd_data, 200);
    read_check("rd_idx400", 400);
    read_check("rd_idx359", 359);

    do_frame(ZONES, 1'b0, 1'b1, 1'b0);
    repeat (6) read_check("rd_rand_b", $urandom_range(ZONES - 1, 0));

    do_frame(ZONES, 1'b0, 1'b0, 1'b0);
    do_frame(ZONES - 1, 1'b0, 1'b0, 1'b0);
    repeat (4) read_check("rd_after_err", $urandom_range(ZONES - 1, 0));
    check_eq("err_sticky", sif.sched_err, 1);

    enter_filter();
    read_check("rd_mid_filter", $urandom_range(ZONES - 1, 0));
    for (int k = 0; k < 20; k++) begin
      sif.light         = 16'($urandom);
      sif.light_index   = 9'($urandom_range(ZONES - 1, 0));
      sif.light_refresh = 1'b1;
      tick();
      ref_mem[~ref_sel][sif.light_index] = sif.light;
      sif.light_refresh = 1'b0;
      tick();
    end
    sys_rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    tick();
    sys_rst   = 1'b1;
    ref_sel   = 1'b0;
    ref_valid = 1'b0;
    tick();
    read_check("rd_post_rst", 7);

    do_frame(ZONES, 1'b0, 1'b0, 1'b1);
    check_eq("rst_frame_bank_sel", sif.bank_sel, 1);
    repeat (6) read_check("rd_rand_e", $urandom_range(ZONES - 1, 0));

    fr0 = fr_cnt;
    enter_filter();
    repeat (TIMEOUT - 1) tick();
    check_eq("timeout_early", sif.sched_err, 0);
    tick();
    check_eq("timeout_err", sif.sched_err, 1);
    repeat (3) tick();
    check_eq("timeout_bank_sel", sif.bank_sel, ref_sel);
    check_eq("timeout_no_ready", fr_cnt - fr0, 0);
    read_check("rd_after_timeout", $urandom_range(ZONES - 1, 0));
    read_check("rd_idx511", 511);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
